pac_sprite_plotter: RTL and testbench

//  Downstream of the pacman movement controller. On each move strobe, it takes the controller's

---
 rtl/pac_sprite_plotter_pkg.sv | 34 +++
 rtl/pac_sprite_plotter_scan.sv | 35 +++
 rtl/pac_sprite_plotter.sv | 146 ++++++++++++++
 tb/tb_pac_sprite_plotter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pac_sprite_plotter_pkg.sv
// Shared constants, state/direction types and tile-to-pixel helpers for the pacman sprite plotter.
package pac_sprite_plotter_pkg;

  localparam int TILE_PX = 5;
  localparam int X_TILES = 27;
  localparam int Y_TILES = 24;

  localparam logic [2:0] PAC_COLOUR = 3'b110;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // tile*5 as shift-and-add; max results 134 (x) and 119 (y) fit the native widths
  function automatic logic [7:0] tile_to_px_x(input logic [7:0] t);
    return (t << 2) + t;
  endfunction

  function automatic logic [6:0] tile_to_px_y(input logic [6:0] t);
    return (t << 2) + t;
  endfunction

endpackage

// File: rtl/pac_sprite_plotter_scan.sv
// 5x5 raster counter: col is the inner index, row the outer; both wrap back to 0 after the last pixel.
module pac_pixel_scan
  import pac_sprite_plotter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic       last
);

  localparam logic [2:0] EDGE_MAX = 3'(TILE_PX - 1);

  assign last = (col == EDGE_MAX) && (row == EDGE_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col <= 3'd0;
      row <= 3'd0;
    end else if (clr) begin
      col <= 3'd0;
      row <= 3'd0;
    end else if (en) begin
      if (col == EDGE_MAX) begin
        col <= 3'd0;
        row <= (row == EDGE_MAX) ? 3'd0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pac_sprite_plotter.sv
// Erases the sprite at the last drawn tile, then draws the new one, one pixel per clock to the VGA adapter.
// state | meaning
// IDLE  | waiting for an in-range go edge
// ERASE | 25 background pixels at the old tile
// DRAW  | 25 shape pixels at the new tile
// DONE  | done pulse next cycle, new tile becomes old; chains to ERASE if a request is pending
module pac_sprite_plotter
  import pac_sprite_plotter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic [7:0]  tile_x,
  input  logic [6:0]  tile_y,
  input  logic [24:0] shape,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  state_e      state, state_nxt;
  logic        go_q;
  logic [7:0]  new_x, old_x, pend_x;
  logic [6:0]  new_y, old_y, pend_y;
  logic [24:0] new_shape, pend_shape;
  logic        old_valid, pending;

  logic [2:0]  col, row;
  logic        last;
  logic        scanning, erasing, req;
  logic [4:0]  bit_idx;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;

  assign req      = go && !go_q && (tile_x < 8'(X_TILES)) && (tile_y < 7'(Y_TILES));
  assign erasing  = (state == S_ERASE);
  assign scanning = erasing || (state == S_DRAW);
  assign busy     = (state != S_IDLE);

  pac_pixel_scan u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (scanning),
    .clr     (!scanning),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = old_valid ? S_ERASE : S_DRAW;
      S_ERASE: if (last) state_nxt = S_DRAW;
      S_DRAW:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = (req || pending) ? S_ERASE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bit_idx    = {row, 2'b00} + 5'(row) + 5'(col);
    pix_x      = (erasing ? tile_to_px_x(old_x) : tile_to_px_x(new_x)) + 8'(col);
    pix_y      = (erasing ? tile_to_px_y(old_y) : tile_to_px_y(new_y)) + 7'(row);
    pix_colour = (!erasing && new_shape[bit_idx]) ? PAC_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= go;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      new_x      <= 8'd0;
      new_y      <= 7'd0;
      new_shape  <= 25'd0;
      old_x      <= 8'd0;
      old_y      <= 7'd0;
      old_valid  <= 1'b0;
      pend_x     <= 8'd0;
      pend_y     <= 7'd0;
      pend_shape <= 25'd0;
      pending    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          new_x     <= tile_x;
          new_y     <= tile_y;
          new_shape <= shape;
        end
        S_ERASE, S_DRAW: if (req) begin
          pending    <= 1'b1;
          pend_x     <= tile_x;
          pend_y     <= tile_y;
          pend_shape <= shape;
        end
        S_DONE: begin
          old_x     <= new_x;
          old_y     <= new_y;
          old_valid <= 1'b1;
          pending   <= 1'b0;
          // a go edge landing in DONE is newer than anything already pending
          if (req) begin
            new_x     <= tile_x;
            new_y     <= tile_y;
            new_shape <= shape;
          end else if (pending) begin
            new_x     <= pend_x;
            new_y     <= pend_y;
            new_shape <= pend_shape;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= BG_COLOUR;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_plot <= scanning;
      done     <= (state == S_DONE);
      if (scanning) begin
        vga_x      <= pix_x;
        vga_y      <= pix_y;
        vga_colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_pac_sprite_plotter.sv
// Directed bench for pac_sprite_plotter: latency, pixel stream, pending/range handling and async reset.
module tb_pac_sprite_plotter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  tile_x = 8'd0;
  logic [6:0]  tile_y = 7'd0;
  logic [24:0] shape = 25'd0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  pac_sprite_plotter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (go),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .shape      (shape),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (vga_plot) got_q.push_back({vga_x, vga_y, vga_colour});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_tile(input int tx, input int ty, input logic [24:0] shp, input bit erase);
    logic [17:0] e;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        e[17:10] = 8'(tx * 5 + c);
        e[9:3]   = 7'(ty * 5 + r);
        e[2:0]   = (!erase && shp[r*5+c]) ? 3'b110 : 3'b000;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic cmp_pixels(input string tag);
    int bad;
    int n;
    bad = 0;
    chk({tag, "_nplots"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_badpix"}, bad, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic start(input int tx, input int ty, input logic [24:0] shp);
    @(negedge clock);
    tile_x = 8'(tx);
    tile_y = 7'(ty);
    shape  = shp;
    go     = 1'b1;
  endtask

  // edges counted from the accepting edge (edge 1) to the edge after which done is seen
  task automatic wait_done(input int limit, output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clock);
      n++;
      #1;
      if (done) seen = 1;
    end
    if (!seen) n = limit + 1;
  endtask

  initial begin
    int n;
    int d0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // first draw after reset: no erase, 27 edges
    add_tile(0, 0, 25'h1FFFFFF, 0);
    start(0, 0, 25'h1FFFFFF);
    wait_done(100, n);
    chk("t1_latency", n, 27);
    chk("t1_busy_after", busy, 0);
    @(negedge clock);
    go = 1'b0;
    repeat (2) @(negedge clock);
    cmp_pixels("t1");
    chk("t1_done_cnt", done_cnt, 1);

    // move to (1,0): erase then draw, 52 edges
    add_tile(0, 0, 25'h0, 1);
    add_tile(1, 0, 25'h0000001, 0);
    start(1, 0, 25'h0000001);
    wait_done(100, n);
    chk("t2_latency", n, 52);
    @(negedge clock);
    go = 1'b0;
    repeat (2) @(negedge clock);
    cmp_pixels("t2");

    // go held high: one request only
    d0 = done_cnt;
    add_tile(1, 0, 25'h0, 1);
    add_tile(2, 0, 25'h0A5A5A5, 0);
    start(2, 0, 25'h0A5A5A5);
    repeat (200) @(negedge clock);
    go = 1'b0;
    repeat (2) @(negedge clock);
    chk("t3_done_cnt", done_cnt - d0, 1);
    cmp_pixels("t3");

    // two extra edges during erase: only the latest is kept and chained
    d0 = done_cnt;
    start(2, 2, 25'h1555555);
    @(negedge clock);
    go = 1'b0;
    repeat (3) @(negedge clock);
    tile_x = 8'd3; tile_y = 7'd3; shape = 25'h0F0F0F0; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    repeat (3) @(negedge clock);
    tile_x = 8'd26; tile_y = 7'd23; shape = 25'h1C00007; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done_cnt - d0 >= 2) break;
    end
    repeat (60) @(negedge clock);
    chk("t4_done_cnt", done_cnt - d0, 2);
    add_tile(2, 0, 25'h0, 1);
    add_tile(2, 2, 25'h1555555, 0);
    add_tile(2, 2, 25'h0, 1);
    add_tile(26, 23, 25'h1C00007, 0);
    cmp_pixels("t4");

    // out-of-range requests are dropped
    d0 = done_cnt;
    start(27, 0, 25'h1FFFFFF);
    @(negedge clock);
    go = 1'b0;
    repeat (60) @(negedge clock);
    start(0, 24, 25'h1FFFFFF);
    @(negedge clock);
    go = 1'b0;
    repeat (60) @(negedge clock);
    chk("t5_plots", got_q.size(), 0);
    chk("t5_done_cnt", done_cnt - d0, 0);
    got_q.delete();
    add_tile(26, 23, 25'h0, 1);
    add_tile(0, 0, 25'h0000421, 0);
    start(0, 0, 25'h0000421);
    wait_done(100, n);
    chk("t5_latency", n, 52);
    @(negedge clock);
    go = 1'b0;
    repeat (2) @(negedge clock);
    cmp_pixels("t5");

    // reset in the middle of DRAW
    start(5, 5, 25'h1FFFFFF);
    @(negedge clock);
    go = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (got_q.size() >= 35) break;
    end
    chk("t6_reached_draw", (got_q.size() >= 35) ? 1 : 0, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_plot", vga_plot, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_x", vga_x, 0);
    chk("t6_y", vga_y, 0);
    chk("t6_colour", vga_colour, 0);
    @(negedge clock);
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    add_tile(3, 4, 25'h1234567, 0);
    start(3, 4, 25'h1234567);
    wait_done(100, n);
    chk("t6_latency", n, 27);
    @(negedge clock);
    go = 1'b0;
    repeat (2) @(negedge clock);
    cmp_pixels("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
